// File: rtl/common_pkg.sv
// Shared constants, FSM encoding and helpers for the stream width converters.
package common_pkg;

  localparam int AXIS_DOWN_RATIO_MAX = 64;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_HOLD  = 1'b1
  } wd_state_e;

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  // Width of a byte-count "mod" field; a 1-byte bus still carries one bit.
  function automatic int mod_width(input int byts);
    return (byts > 1) ? $clog2(byts) : 1;
  endfunction

endpackage

// File: rtl/if_axi_stream.sv
// Byte-oriented streaming bus with packet framing (sop/eop/mod), sideband ctl and err.
interface if_axi_stream #(
  parameter int DAT_BYTS = 8,
  parameter int CTL_BITS = 8
);
  localparam int MOD_W = (DAT_BYTS > 1) ? $clog2(DAT_BYTS) : 1;

  logic                  val;
  logic                  rdy;
  logic                  sop;
  logic                  eop;
  logic                  err;
  logic [DAT_BYTS*8-1:0] dat;
  logic [MOD_W-1:0]      mod;
  logic [CTL_BITS-1:0]   ctl;

  modport source (output val, sop, eop, err, dat, mod, ctl, input rdy);
  modport sink   (input val, sop, eop, err, dat, mod, ctl, output rdy);
endinterface

// File: rtl/axi_stream_width_down_chk.sv
// Simulation-only protocol checker for the wide input side of axi_stream_width_down.
module axi_stream_width_down_chk
  import common_pkg::*;
#(
  parameter int IN_BYTS  = 64,
  parameter int OUT_BYTS = 8
) (
  input logic                 i_clk,
  input logic                 i_rst,
  input logic                 i_val,
  input logic                 i_rdy,
  input logic                 i_sop,
  input logic                 i_eop,
  input logic [IN_BYTS*8-1:0] i_dat
);

  logic                 stall_q;
  logic                 open_q;
  logic [IN_BYTS*8-1:0] dat_q;

  always_ff @(posedge i_clk) begin
    assert ((IN_BYTS % OUT_BYTS == 0) && (IN_BYTS / OUT_BYTS <= AXIS_DOWN_RATIO_MAX))
      else $fatal(1, "axis_width_down: IN_BYTS must be a multiple of OUT_BYTS");
    if (i_rst) begin
      stall_q <= 1'b0;
      open_q  <= 1'b0;
      dat_q   <= '0;
    end else begin
      if (stall_q) begin
        assert (i_val && (i_dat == dat_q))
          else $fatal(1, "axis_width_down: input beat dropped or changed while stalled");
      end
      if (i_val) begin
        assert (!(i_sop && open_q))
          else $fatal(1, "axis_width_down: sop while a packet is open");
        assert (i_sop || open_q)
          else $fatal(1, "axis_width_down: beat without a preceding sop");
      end
      if (i_val && i_rdy) begin
        open_q <= !i_eop;
      end
      stall_q <= i_val && !i_rdy;
      dat_q   <= i_dat;
    end
  end

endmodule

// File: rtl/axi_stream_width_down.sv
// Wide-to-narrow stream converter: holds one wide beat and emits it LSB-first as narrow slices.
// Optional protocol checker enabled by defining AXIS_WIDTH_DOWN_CHECK_EN.
//
// state    | meaning
// ST_EMPTY | no beat held, input ready
// ST_HOLD  | beat held, slice idx_q presented on the output
module axi_stream_width_down
  import common_pkg::*;
#(
  parameter int IN_BYTS  = 64,
  parameter int OUT_BYTS = 8,
  parameter int CTL_BITS = 8
) (
  input logic           i_clk,
  input logic           i_rst,
  if_axi_stream.sink    i_axi,
  if_axi_stream.source  o_axi
);

  localparam int R      = IN_BYTS / OUT_BYTS;
  localparam int OUT_W  = OUT_BYTS * 8;
  localparam int IDX_W  = $clog2(R);
  localparam int IMOD_W = mod_width(IN_BYTS);
  localparam int OMOD_W = mod_width(OUT_BYTS);

  typedef logic [IDX_W-1:0]  idx_t;
  typedef logic [IMOD_W:0]   vld_t;
  typedef logic [OMOD_W-1:0] lmod_t;

  typedef struct packed {
    logic [R-1:0][OUT_W-1:0] dat;
    logic                    sop;
    logic                    eop;
    logic                    err;
    logic [CTL_BITS-1:0]     ctl;
    idx_t                    last_idx;
    lmod_t                   lmod;
  } hold_t;

  wd_state_e state_q, state_d;
  idx_t      idx_q, idx_d;
  hold_t     hold_q, hold_d, cap;
  vld_t      cap_valid;
  logic      held, last_slice, eop_slice, in_rdy, in_xfer, out_xfer;

  assign held       = (state_q == ST_HOLD);
  assign last_slice = (idx_q == hold_q.last_idx);
  assign eop_slice  = held && hold_q.eop && last_slice;
  assign in_rdy     = !i_rst && (!held || (o_axi.rdy && last_slice));
  assign in_xfer    = i_axi.val && in_rdy;
  assign out_xfer   = held && o_axi.rdy;
  assign i_axi.rdy  = in_rdy;

  // Slice bookkeeping is resolved at capture so the output path is a plain mux.
  always_comb begin
    cap_valid    = (i_axi.eop && (i_axi.mod != '0)) ? vld_t'(i_axi.mod) : vld_t'(IN_BYTS);
    cap.dat      = i_axi.dat;
    cap.sop      = i_axi.sop;
    cap.eop      = i_axi.eop;
    cap.err      = i_axi.err && i_axi.eop;
    cap.ctl      = i_axi.ctl;
    cap.last_idx = idx_t'(ceil_div(int'(cap_valid), OUT_BYTS) - 1);
    cap.lmod     = lmod_t'(int'(cap_valid) % OUT_BYTS);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_EMPTY;
      idx_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    hold_d  = hold_q;
    if (out_xfer) begin
      if (last_slice) begin
        state_d = ST_EMPTY;
        idx_d   = '0;
      end else begin
        idx_d = idx_q + idx_t'(1);
      end
    end
    // A capture on the final-slice cycle overrides the drain: no bubble.
    if (in_xfer) begin
      state_d = ST_HOLD;
      idx_d   = '0;
      hold_d  = cap;
    end
  end

  always_comb begin
    o_axi.val = held;
    o_axi.dat = hold_q.dat[idx_q];
    o_axi.sop = held && hold_q.sop && (idx_q == '0);
    o_axi.eop = eop_slice;
    o_axi.mod = eop_slice ? hold_q.lmod : '0;
    o_axi.ctl = hold_q.ctl;
    o_axi.err = eop_slice && hold_q.err;
  end

`ifdef AXIS_WIDTH_DOWN_CHECK_EN
  axi_stream_width_down_chk #(
    .IN_BYTS  (IN_BYTS),
    .OUT_BYTS (OUT_BYTS)
  ) u_chk (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_val (i_axi.val),
    .i_rdy (in_rdy),
    .i_sop (i_axi.sop),
    .i_eop (i_axi.eop),
    .i_dat (i_axi.dat)
  );
`else
`endif

endmodule

// File: tb/tb_axi_stream_width_down.sv
// Randomized bench for axi_stream_width_down: packet-level byte queues as reference, per-cycle compare.
module tb_axi_stream_width_down;
  localparam int IN_BYTS  = 64;
  localparam int OUT_BYTS = 8;
  localparam int CTL_BITS = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  if_axi_stream #(.DAT_BYTS(IN_BYTS),  .CTL_BITS(CTL_BITS)) in_if ();
  if_axi_stream #(.DAT_BYTS(OUT_BYTS), .CTL_BITS(CTL_BITS)) out_if ();

  axi_stream_width_down #(
    .IN_BYTS  (IN_BYTS),
    .OUT_BYTS (OUT_BYTS),
    .CTL_BITS (CTL_BITS)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .i_axi (in_if),
    .o_axi (out_if)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference: every byte still owed, plus per-packet length / ctl / err.
  byte unsigned exp_bytes[$];
  int           exp_len[$];
  logic [7:0]   exp_ctl[$];
  bit           exp_err[$];

  int bp_pct  = 0;
  int gap_pct = 0;

  int cyc = 0, slice_in_pkt = 0, act_slices = 0, xfer_total = 0, pkt_done = 0;
  int last_slices = 0, last_mod = 0;
  bit last_rdy_at_eop = 1'b0;
  int first_val_cyc = -1, last_xfer_cyc = 0, win_xfer = 0, win_in_rdy = 0;

  bit         stall_q = 1'b0;
  logic [63:0] s_dat;
  logic        s_sop, s_eop, s_err;
  logic [2:0]  s_mod;
  logic [7:0]  s_ctl;

  task automatic chk(input bit ok, input string name, input longint act, input longint req);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic abort_run(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: bound expired", name);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  endtask

  initial begin
    out_if.rdy = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_if.rdy = ($urandom_range(0, 99) >= bp_pct);
    end
  end

  always @(negedge clk) begin : collector
    int plen, nsl, nb, emod;
    bit esop, eeop, eerr, ok, beat_last;
    logic [7:0] ectl;
    cyc++;
    if (rst) begin
      chk(in_if.rdy == 1'b0, "rst_in_rdy", in_if.rdy, 0);
      slice_in_pkt = 0;
      act_slices   = 0;
      stall_q      = 1'b0;
    end else begin
      if (stall_q) begin
        ok = out_if.val && out_if.dat == s_dat && out_if.sop == s_sop && out_if.eop == s_eop &&
             out_if.mod == s_mod && out_if.ctl == s_ctl && out_if.err == s_err;
        chk(ok, "stall_hold", {out_if.val, out_if.sop, out_if.eop, out_if.err, out_if.dat},
            {1'b1, s_sop, s_eop, s_err, s_dat});
      end
      if (out_if.val && first_val_cyc < 0) first_val_cyc = cyc;
      if (out_if.val && in_if.rdy) win_in_rdy++;
      if (!out_if.val) begin
        chk(in_if.rdy == 1'b1, "idle_in_rdy", in_if.rdy, 1);
      end else begin
        chk(exp_len.size() != 0, "slice_expected", 1, 0);
        if (exp_len.size() != 0) begin
          plen = exp_len[0];
          nsl  = (plen + 7) / 8;
          beat_last = (slice_in_pkt % 8 == 7) || (slice_in_pkt == nsl - 1);
          chk(in_if.rdy == (out_if.rdy && beat_last), "in_rdy", in_if.rdy, out_if.rdy && beat_last);
          if (out_if.rdy) begin
            esop = (slice_in_pkt == 0);
            eeop = (slice_in_pkt == nsl - 1);
            nb   = eeop ? plen - 8 * slice_in_pkt : 8;
            emod = eeop ? plen % 8 : 0;
            eerr = eeop && exp_err[0];
            ectl = exp_ctl[0];
            ok = out_if.sop == esop && out_if.eop == eeop && int'(out_if.mod) == emod &&
                 out_if.ctl == ectl && out_if.err == eerr && exp_bytes.size() >= nb;
            if (exp_bytes.size() >= nb)
              for (int b = 0; b < nb; b++)
                if (out_if.dat[8*b +: 8] != exp_bytes[b]) ok = 1'b0;
            n_tests++;
            if (!ok) begin
              n_fail++;
              $display("FAIL slice pkt=%0d idx=%0d actual sop=%0b eop=%0b mod=%0d ctl=%0h err=%0b dat=%016h required sop=%0b eop=%0b mod=%0d ctl=%0h err=%0b nbytes=%0d",
                       pkt_done, slice_in_pkt, out_if.sop, out_if.eop, out_if.mod, out_if.ctl, out_if.err,
                       out_if.dat, esop, eeop, emod, ectl, eerr, nb);
            end
            for (int b = 0; b < nb; b++)
              if (exp_bytes.size() != 0) void'(exp_bytes.pop_front());
            xfer_total++;
            win_xfer++;
            last_xfer_cyc = cyc;
            act_slices++;
            if (out_if.eop) begin
              last_slices     = act_slices;
              last_mod        = int'(out_if.mod);
              last_rdy_at_eop = in_if.rdy;
              act_slices      = 0;
            end
            slice_in_pkt++;
            if (eeop) begin
              pkt_done++;
              void'(exp_len.pop_front());
              void'(exp_ctl.pop_front());
              void'(exp_err.pop_front());
              slice_in_pkt = 0;
            end
          end
        end
      end
      stall_q = out_if.val && !out_if.rdy;
      s_dat = out_if.dat; s_sop = out_if.sop; s_eop = out_if.eop;
      s_err = out_if.err; s_mod = out_if.mod; s_ctl = out_if.ctl;
    end
  end

  task automatic put_stream(input int len, input logic [7:0] ctl);
    byte unsigned pb[$];
    logic [511:0] d;
    bit perr;
    int nbeats, idx, w;
    perr = ($urandom_range(0, 3) == 0);
    for (int i = 0; i < len; i++) begin
      pb.push_back(8'($urandom));
      exp_bytes.push_back(pb[i]);
    end
    exp_len.push_back(len);
    exp_ctl.push_back(ctl);
    exp_err.push_back(perr);
    nbeats = (len + 63) / 64;
    for (int bt = 0; bt < nbeats; bt++) begin
      while (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
        in_if.val = 1'b0;
        @(posedge clk);
        #1;
      end
      for (int b = 0; b < 64; b++) begin
        idx = bt * 64 + b;
        d[8*b +: 8] = (idx < len) ? pb[idx] : 8'($urandom);
      end
      in_if.dat = d;
      in_if.sop = (bt == 0);
      in_if.eop = (bt == nbeats - 1);
      in_if.mod = (bt == nbeats - 1) ? 6'(len % 64) : 6'($urandom);
      in_if.err = (bt == nbeats - 1) ? perr : 1'($urandom);
      in_if.ctl = ctl;
      in_if.val = 1'b1;
      w = 0;
      @(negedge clk);
      while (!in_if.rdy && w < 2000) begin
        @(negedge clk);
        w++;
      end
      if (!in_if.rdy) abort_run("in_accept_timeout");
      @(posedge clk);
      #1;
    end
    in_if.val = 1'b0;
  endtask

  task automatic drain();
    int w = 0;
    while (exp_len.size() != 0 && w < 20000) begin
      @(negedge clk);
      #1;
      w++;
    end
    if (exp_len.size() != 0) abort_run("drain_timeout");
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    int pd, base, w;
    in_if.val = 1'b0; in_if.dat = '0; in_if.sop = 1'b0; in_if.eop = 1'b0;
    in_if.err = 1'b0; in_if.mod = '0; in_if.ctl = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk({out_if.val, out_if.sop, out_if.eop, out_if.err} == 4'b0, "rst_flags",
        {out_if.val, out_if.sop, out_if.eop, out_if.err}, 0);
    chk(out_if.dat == 64'h0, "rst_dat", out_if.dat, 0);
    chk(out_if.mod == 3'h0 && out_if.ctl == 8'h0, "rst_mod_ctl", {out_if.mod, out_if.ctl}, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    pd = pkt_done;
    put_stream(64, 8'h11);
    drain();
    chk(pkt_done == pd + 1, "p64_done", pkt_done - pd, 1);
    chk(last_slices == 8, "p64_slices", last_slices, 8);
    chk(last_mod == 0, "p64_mod", last_mod, 0);

    put_stream(70, 8'h22);
    drain();
    chk(last_slices == 9, "p70_slices", last_slices, 9);
    chk(last_mod == 6, "p70_mod", last_mod, 6);

    put_stream(17, 8'h44);
    drain();
    chk(last_slices == 3, "p17_slices", last_slices, 3);
    chk(last_mod == 1, "p17_mod", last_mod, 1);
    chk(last_rdy_at_eop == 1'b1, "p17_rdy_at_last", last_rdy_at_eop, 1);

    pd = pkt_done;
    first_val_cyc = -1; win_xfer = 0; win_in_rdy = 0;
    put_stream(128, 8'h5A);
    put_stream(128, 8'h5A);
    drain();
    chk(pkt_done == pd + 2, "b2b_done", pkt_done - pd, 2);
    chk(win_xfer == 32, "b2b_xfers", win_xfer, 32);
    chk(last_xfer_cyc - first_val_cyc + 1 == 32, "b2b_span", last_xfer_cyc - first_val_cyc + 1, 32);
    chk(win_in_rdy == 4, "b2b_in_rdy", win_in_rdy, 4);

    pd = pkt_done;
    bp_pct = 50; gap_pct = 10;
    for (int p = 0; p < 1000; p++) put_stream($urandom_range(1, 512), 8'($urandom));
    drain();
    chk(pkt_done == pd + 1000, "rand_done", pkt_done - pd, 1000);

    bp_pct = 0; gap_pct = 0;
    repeat (2) @(posedge clk);
    #1;
    base = xfer_total;
    put_stream(64, 8'h33);
    w = 0;
    while (xfer_total < base + 3 && w < 100) begin
      @(negedge clk);
      #1;
      w++;
    end
    if (xfer_total < base + 3) abort_run("rst_slices_timeout");
    @(posedge clk);
    #1 rst = 1'b1;
    exp_bytes.delete(); exp_len.delete(); exp_ctl.delete(); exp_err.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk(out_if.val == 1'b0, "val_after_rst", out_if.val, 0);
    chk(in_if.rdy == 1'b1, "rdy_after_rst", in_if.rdy, 1);
    @(posedge clk);
    #1;
    pd = pkt_done;
    put_stream(16, 8'hC3);
    drain();
    chk(pkt_done == pd + 1, "p16_done", pkt_done - pd, 1);
    chk(last_slices == 2, "p16_slices", last_slices, 2);
    chk(last_mod == 0, "p16_mod", last_mod, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #3000000;
    abort_run("watchdog");
  end

endmodule
